switch_allocator: RTL and testbench

SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

---
 rtl/switch_allocator.sv | 150 +++++++++++++++
 tb/tb_switch_allocator.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
// Module   : switch_allocator
// Brief    : Per-output round-robin wormhole switch allocator for a mesh router.
// Revision : 1.0 - initial release
// ============================================================================
module switch_allocator #(
    parameter int PORTS         = 5,
    parameter int REQUEST_WIDTH = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PORTS-1:0]                 in_valid,
    input  logic [PORTS-1:0]                 in_head,
    input  logic [PORTS-1:0]                 in_tail,
    input  logic [PORTS*REQUEST_WIDTH-1:0]   in_request,
    input  logic [PORTS-1:0]                 out_ready,
    output logic [PORTS-1:0]                 in_ready,
    output logic [PORTS-1:0]                 out_valid,
    output logic [PORTS*$clog2(PORTS)-1:0]   sel,
    output logic [PORTS-1:0]                 busy,
    output logic                             err_bad_request
);

    localparam int c_SEL_W = $clog2(PORTS);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    logic [REQUEST_WIDTH-1:0] w_reqCode [PORTS];
    logic [PORTS-1:0]         w_headValid;
    logic [PORTS-1:0]         w_badRequest;
    logic [PORTS-1:0]         w_lockedInput;
    logic [PORTS-1:0]         w_locked;
    logic [c_SEL_W-1:0]       w_owner [PORTS];
    logic                     r_errBadRequest;

    for (genvar i = 0; i < PORTS; i++) begin : g_in
        assign w_reqCode[i]    = in_request[i*REQUEST_WIDTH +: REQUEST_WIDTH];
        assign w_headValid[i]  = in_valid[i] & in_head[i];
        assign w_badRequest[i] = w_headValid[i] && (32'(w_reqCode[i]) >= 32'(PORTS));
    end

    // An input already holding an output may not compete for another one.
    always_comb begin
        w_lockedInput = '0;
        for (int o = 0; o < PORTS; o++) begin
            if (w_locked[o]) begin
                w_lockedInput[w_owner[o]] = 1'b1;
            end
        end
    end

    for (genvar o = 0; o < PORTS; o++) begin : g_out
        state_t             r_state;
        logic [c_SEL_W-1:0] r_owner;
        logic [c_SEL_W-1:0] r_rrPtr;
        logic [PORTS-1:0]   w_cand;
        logic               w_grantValid;
        logic [c_SEL_W-1:0] w_grantIdx;
        logic               w_release;
        int                 idx;

        always_comb begin
            w_cand = '0;
            for (int i = 0; i < PORTS; i++) begin
                w_cand[i] = w_headValid[i] && !w_lockedInput[i]
                            && (w_reqCode[i] == REQUEST_WIDTH'(o));
            end
        end

        // Scan from the far end so the candidate nearest rr_ptr is the last write.
        always_comb begin
            w_grantValid = 1'b0;
            w_grantIdx   = '0;
            idx          = 0;
            for (int k = PORTS - 1; k >= 0; k--) begin
                idx = int'(r_rrPtr) + k;
                if (idx >= PORTS) begin
                    idx = idx - PORTS;
                end
                if (w_cand[c_SEL_W'(idx)]) begin
                    w_grantValid = 1'b1;
                    w_grantIdx   = c_SEL_W'(idx);
                end
            end
        end

        assign w_release = (r_state == LOCKED) && out_ready[o]
                           && in_valid[r_owner] && in_tail[r_owner];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state <= IDLE;
                r_owner <= '0;
                r_rrPtr <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_grantValid) begin
                            r_owner <= w_grantIdx;
                            r_state <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (w_release) begin
                            r_state <= IDLE;
                            r_rrPtr <= (r_owner == c_SEL_W'(PORTS - 1)) ? '0
                                                                       : r_owner + c_SEL_W'(1);
                        end
                    end
                endcase
            end
        end

        assign w_locked[o] = (r_state == LOCKED);
        assign w_owner[o]  = r_owner;
    end

    always_comb begin
        in_ready  = '0;
        out_valid = '0;
        sel       = '0;
        busy      = '0;
        for (int o = 0; o < PORTS; o++) begin
            if (w_locked[o]) begin
                busy[o]                       = 1'b1;
                sel[o*c_SEL_W +: c_SEL_W]     = w_owner[o];
                out_valid[o]                  = in_valid[w_owner[o]];
                if (out_ready[o]) begin
                    in_ready[w_owner[o]] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_errBadRequest <= 1'b0;
        end else if (|w_badRequest) begin
            r_errBadRequest <= 1'b1;
        end
    end

    assign err_bad_request = r_errBadRequest;

endmodule
`default_nettype wire

// File: tb/tb_switch_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_allocator
// Brief    : Directed and random checks of switch_allocator against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_allocator;

    localparam int PORTS = 5;
    localparam int RW    = 3;
    localparam int SW    = $clog2(PORTS);

    logic                  clk = 1'b0;
    logic                  rst;
    logic [PORTS-1:0]      in_valid, in_head, in_tail, out_ready;
    logic [PORTS*RW-1:0]   in_request;
    logic [PORTS-1:0]      in_ready, out_valid, busy;
    logic [PORTS*SW-1:0]   sel;
    logic                  err_bad_request;

    int checks   = 0;
    int failures = 0;

    // Reference model: owner index per output (-1 when free), round-robin start, error flag.
    int mOwner [PORTS];
    int mRr    [PORTS];
    bit mErr;

    int expBusy30 [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    int expSel30  [8] = '{0, 0, 0, 3, 0, 4, 0, 0};

    switch_allocator #(.PORTS(PORTS), .REQUEST_WIDTH(RW)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_head         (in_head),
        .in_tail         (in_tail),
        .in_request      (in_request),
        .out_ready       (out_ready),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .sel             (sel),
        .busy            (busy),
        .err_bad_request (err_bad_request)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] selOf(input int o);
        return 32'(sel[o*SW +: SW]);
    endfunction

    function automatic int reqOf(input int i);
        return int'(in_request[i*RW +: RW]);
    endfunction

    task automatic drive(input int i, input bit v, input bit h, input bit t, input int req);
        in_valid[i]          = v;
        in_head[i]           = h;
        in_tail[i]           = t;
        in_request[i*RW +: RW] = RW'(req);
    endtask

    task automatic clearInputs();
        in_valid   = '0;
        in_head    = '0;
        in_tail    = '0;
        in_request = '0;
    endtask

    task automatic modelReset();
        for (int o = 0; o < PORTS; o++) begin
            mOwner[o] = -1;
            mRr[o]    = 0;
        end
        mErr = 1'b0;
    endtask

    function automatic bit isCandidate(input int i, input int o);
        if (!(in_valid[i] && in_head[i] && reqOf(i) == o)) return 1'b0;
        for (int p = 0; p < PORTS; p++) begin
            if (mOwner[p] == i) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        logic [PORTS-1:0]    eReady, eValid, eBusy;
        logic [PORTS*SW-1:0] eSel;
        int                  nOwner [PORTS];
        int                  nRr    [PORTS];
        bit                  nErr;
        #1;
        eReady = '0;
        eValid = '0;
        eBusy  = '0;
        eSel   = '0;
        for (int o = 0; o < PORTS; o++) begin
            if (mOwner[o] >= 0) begin
                eBusy[o]          = 1'b1;
                eSel[o*SW +: SW]  = SW'(mOwner[o]);
                eValid[o]         = in_valid[mOwner[o]];
                if (out_ready[o]) eReady[mOwner[o]] = 1'b1;
            end
        end
        check("in_ready",  32'(in_ready),  32'(eReady));
        check("out_valid", 32'(out_valid), 32'(eValid));
        check("busy",      32'(busy),      32'(eBusy));
        check("sel",       32'(sel),       32'(eSel));
        check("err",       32'(err_bad_request), 32'(mErr));

        nErr = mErr;
        for (int i = 0; i < PORTS; i++) begin
            if (in_valid[i] && in_head[i] && reqOf(i) >= PORTS) nErr = 1'b1;
        end
        for (int o = 0; o < PORTS; o++) begin
            nOwner[o] = mOwner[o];
            nRr[o]    = mRr[o];
            if (mOwner[o] >= 0) begin
                if (out_ready[o] && in_valid[mOwner[o]] && in_tail[mOwner[o]]) begin
                    nOwner[o] = -1;
                    nRr[o]    = (mOwner[o] + 1) % PORTS;
                end
            end else begin
                for (int k = 0; k < PORTS; k++) begin
                    int i;
                    i = (mRr[o] + k) % PORTS;
                    if (nOwner[o] < 0 && isCandidate(i, o)) nOwner[o] = i;
                end
            end
        end
        @(posedge clk);
        mOwner = nOwner;
        mRr    = nRr;
        mErr   = nErr;
        @(negedge clk);
    endtask

    // Asserts reset mid-cycle and checks outputs drop before any clock edge.
    task automatic doReset();
        rst = 1'b0;
        #1;
        check("rst_busy",      32'(busy),            32'(0));
        check("rst_in_ready",  32'(in_ready),        32'(0));
        check("rst_sel",       32'(sel),             32'(0));
        check("rst_out_valid", 32'(out_valid),       32'(0));
        check("rst_err",       32'(err_bad_request), 32'(0));
        modelReset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        out_ready = '1;
        clearInputs();
        modelReset();
        @(negedge clk);
        doReset();

        // Three-flit packet from input 2 to output 1.
        drive(2, 1, 1, 0, 1);
        #1 check("p29_no_early_grant", 32'(busy[1]), 32'(0));
        step();
        #1 check("p29_busy", 32'(busy[1]), 32'(1));
        check("p29_sel", selOf(1), 32'(2));
        check("p29_head_ready", 32'(in_ready[2]), 32'(1));
        step();
        drive(2, 1, 0, 0, 1);
        #1 check("p29_body_ready", 32'(in_ready[2]), 32'(1));
        step();
        drive(2, 1, 0, 1, 1);
        #1 check("p29_tail_ready", 32'(in_ready[2]), 32'(1));
        step();
        clearInputs();
        #1 check("p29_released", 32'(busy[1]), 32'(0));
        step();

        // Round-robin among inputs 0, 3, 4 holding single-flit packets to output 2.
        doReset();
        drive(0, 1, 1, 1, 2);
        drive(3, 1, 1, 1, 2);
        drive(4, 1, 1, 1, 2);
        for (int c = 0; c < 8; c++) begin
            #1 check("p30_busy", 32'(busy[2]), 32'(expBusy30[c]));
            check("p30_sel", selOf(2), 32'(expSel30[c]));
            step();
        end
        clearInputs();

        // Back-pressure on output 4 in the middle of a packet.
        doReset();
        drive(1, 1, 1, 0, 4);
        step();
        #1 check("p31_head_ready", 32'(in_ready[1]), 32'(1));
        step();
        drive(1, 1, 0, 0, 4);
        out_ready[4] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1 check("p31_stall_ready", 32'(in_ready[1]), 32'(0));
            check("p31_stall_busy", 32'(busy[4]), 32'(1));
            check("p31_stall_valid", 32'(out_valid[4]), 32'(1));
            step();
        end
        out_ready[4] = 1'b1;
        #1 check("p31_resume", 32'(in_ready[1]), 32'(1));
        step();
        drive(1, 1, 0, 1, 4);
        step();
        clearInputs();
        #1 check("p31_released", 32'(busy[4]), 32'(0));
        step();

        // Single-flit packet from input 1 to output 0.
        doReset();
        drive(1, 1, 1, 1, 0);
        step();
        #1 check("p32_ready", 32'(in_ready[1]), 32'(1));
        check("p32_busy", 32'(busy[0]), 32'(1));
        step();
        clearInputs();
        #1 check("p32_idle", 32'(busy[0]), 32'(0));
        step();

        // Out-of-range request code is ignored and flagged.
        doReset();
        drive(3, 1, 1, 0, 6);
        step();
        for (int c = 0; c < 3; c++) begin
            #1 check("p33_err", 32'(err_bad_request), 32'(1));
            check("p33_no_grant", 32'(busy), 32'(0));
            check("p33_no_ready", 32'(in_ready), 32'(0));
            step();
        end
        clearInputs();
        step();
        #1 check("p33_sticky", 32'(err_bad_request), 32'(1));
        step();

        // Asynchronous reset while outputs 1 and 3 are locked.
        doReset();
        drive(0, 1, 1, 0, 1);
        drive(2, 1, 1, 0, 3);
        step();
        #1 check("p34_locked", 32'(busy), 32'(5'b01010));
        check("p34_ready_before", 32'(in_ready), 32'(5'b00101));
        #1 doReset();
        step();
        step();
        clearInputs();

        // Random traffic against the model, with occasional resets.
        doReset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < PORTS; i++) begin
                int req;
                req = ($urandom_range(0, 29) == 0) ? int'($urandom_range(5, 7))
                                                    : int'($urandom_range(0, PORTS - 1));
                drive(i, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 2) == 0, req);
            end
            out_ready = PORTS'($urandom);
            if ($urandom_range(0, 49) == 0) doReset();
            else step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
